// File: rtl/ascon_round_sched.sv
// Counted, handshaked Ascon round-constant scheduler for p^12 / p^8 / p^6 with UNROLL rounds per clock.
// Optional abort input is enabled by defining ASCON_ROUND_SCHED_ABORT_EN.
module ascon_round_sched #(
   parameter int UNROLL = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          mode,
`ifdef ASCON_ROUND_SCHED_ABORT_EN
   input  logic                abort,
`endif
   output logic                ready,
   output logic                busy,
   output logic                round_en,
   output logic                last,
   output logic [8*UNROLL-1:0] rc,
   output logic                done,
   output logic                err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
   localparam logic [3:0] CNT12 = 4'(12 / UNROLL);
   localparam logic [3:0] CNT8  = 4'(8 / UNROLL);
   localparam logic [3:0] CNT6  = 4'(6 / UNROLL);

   if ((UNROLL != 1) && (UNROLL != 2)) begin : g_bad_unroll
      $error("ascon_round_sched: UNROLL must be 1 or 2");
   end

   logic [1:0]          state_r, state_s;
   logic [3:0]          cnt_r, cnt_s;
   logic [8*UNROLL-1:0] rc_r, rc_s;
   logic                err_r, err_s;
   logic                abort_s;

`ifdef ASCON_ROUND_SCHED_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   // One Ascon constant step: upper nibble counts down, lower nibble counts up.
   function automatic logic [7:0] step(input logic [7:0] x);
      step = {x[7:4] - 4'd1, x[3:0] + 4'd1};
   endfunction

   function automatic logic [8*UNROLL-1:0] lanes(input logic [7:0] first);
      logic [7:0] x;
      lanes = '0;
      x     = first;
      for (int k = 0; k < UNROLL; k++) begin
         lanes[8*k +: 8] = x;
         x               = step(x);
      end
   endfunction

   function automatic logic [7:0] start_rc(input logic [1:0] m);
      case (m)
         2'b00:   start_rc = 8'hF0;
         2'b01:   start_rc = 8'hB4;
         default: start_rc = 8'h96;
      endcase
   endfunction

   function automatic logic [3:0] load_cnt(input logic [1:0] m);
      case (m)
         2'b00:   load_cnt = CNT12;
         2'b01:   load_cnt = CNT8;
         default: load_cnt = CNT6;
      endcase
   endfunction

   // Next-state, counter and constant update; the final round keeps its constant on rc.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      rc_s    = rc_r;
      err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (abort_s) begin
               state_s = IDLE;
            end else if (start && (mode == 2'b11)) begin
               err_s = 1'b1;
            end else if (start) begin
               state_s = RUN;
               cnt_s   = load_cnt(mode);
               rc_s    = lanes(start_rc(mode));
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (abort_s) begin
               state_s = IDLE;
               cnt_s   = 4'd0;
            end else if (cnt_r == 4'd1) begin
               state_s = DONE;
               cnt_s   = cnt_r - 4'd1;
            end else begin
               state_s = RUN;
               cnt_s   = cnt_r - 4'd1;
               rc_s    = lanes(step(rc_r[8*UNROLL-1 -: 8]));
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= 4'd0;
         rc_r    <= '0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         rc_r    <= rc_s;
         err_r   <= err_s;
      end
   end

   assign ready    = (state_r == IDLE);
   assign busy     = (state_r == RUN);
   assign round_en = (state_r == RUN);
   assign last     = (state_r == RUN) && (cnt_r == 4'd1);
   assign done     = (state_r == DONE);
   assign err      = err_r;
   assign rc       = rc_r;

endmodule

// File: doc/ascon_round_sched.md
# ascon_round_sched

Round scheduler for the Ascon permutation datapath. Accepts a permutation request for p^12, p^8 or p^6 and produces the per-cycle round enable and 8-bit round constant(s). Constants follow the Ascon sequence: upper nibble decrements and lower nibble increments by one per round. Sits between the mode FSM (initialisation, associated data, text, finalisation) and the round-function datapath, replacing a free-running constant generator with a counted, handshaked sequence.

## Interface
Parameters:
- UNROLL, 1, rounds executed per clock by the datapath; legal values 1 or 2. Other values are a synthesis-time error (generate-time $error).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a permutation; accepted when start && ready
- mode  input  2  round count select: 2'b00 = 12, 2'b01 = 8, 2'b10 = 6, 2'b11 = illegal
- ready  output  1  scheduler idle, can accept start
- busy  output  1  permutation in progress
- round_en  output  1  datapath applies UNROLL rounds this cycle
- last  output  1  current round_en cycle is the final one
- rc  output  8*UNROLL  round constants; rc[7:0] = first round of the cycle, rc[15:8] = second (UNROLL=2)
- done  output  1  one-cycle pulse, permutation complete
- err  output  1  one-cycle pulse, start with mode 2'b11 rejected
- abort  input  1  present only with ASCON_ROUND_SCHED_ABORT_EN

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- Outputs at reset: ready=1, busy=0, round_en=0, last=0, done=0, err=0, rc=0, internal round counter=0.
- IDLE: ready=1. start && mode!=2'b11: load rc register with start constant (12 -> 8'hF0, 8 -> 8'hB4, 6 -> 8'h96), load counter with N/UNROLL, go RUN. start && mode==2'b11: stay IDLE, err=1 next cycle, no registers change.
- RUN: busy=1, round_en=1, ready=0. Each cycle rc register advances UNROLL steps; counter decrements by 1. last=1 when counter==1; on that cycle transition to DONE.
- Step function: step(x) = {x[7:4]-4'd1, x[3:0]+4'd1}, each nibble mod 16. For UNROLL=2, rc[15:8] = step(rc[7:0]) combinationally.
- DONE: done=1, busy=0, round_en=0, ready=0; unconditionally return to IDLE next cycle.
- Final constant always 8'h4B (rc[15:8] in the final UNROLL=2 cycle).
- start while not ready: ignored, not queued. mode sampled only on acceptance.
- rc holds its last value in DONE/IDLE until the next accepted start.

## Timing
- Start accepted at edge T -> round_en high for cycles T+1 .. T+N/UNROLL -> done high in cycle T+N/UNROLL+1 -> ready high from T+N/UNROLL+2.
- UNROLL=1: p^12 occupies 14 cycles start-to-ready; p^6 occupies 8.
- UNROLL=2: p^12 -> 6 round_en cycles; p^8 -> 4; p^6 -> 3.
- rc, round_en, last are registered/decoded from state; valid in the same cycle as round_en.
- err asserted in the cycle after the rejected start, for exactly one cycle.
- rst_n low mid-RUN: all outputs return to reset values immediately (asynchronously); no done.

## Configuration
- ASCON_ROUND_SCHED_ABORT_EN defined: abort port exists. abort=1 in RUN or DONE -> next state IDLE, round_en=0, done not asserted, counter cleared. abort in IDLE: start in that cycle ignored (abort has priority), no err.
- Undefined: no abort port; a permutation always runs to done.

## Test plan
- UNROLL=1, start with mode=00 -> round_en for 12 cycles, rc = F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B, last only with 4B, done one cycle later.
- UNROLL=1, mode=10 -> rc = 96,87,78,69,5A,4B; mode=01 -> starts B4, 8 round_en cycles, ends 4B.
- UNROLL=2, mode=00 -> 6 cycles, {rc[15:8],rc[7:0]} = {E1,F0},{C3,D2},...,{4B,5A}; done at cycle 7 after acceptance.
- start with mode=11 -> err pulse next cycle, ready stays 1, round_en never asserts; start held high during RUN -> not re-accepted until ready returns.
- rst_n pulsed low at round 5 of p^12 -> outputs at reset values immediately, no done; new start afterwards restarts at F0.
- ABORT_EN: abort at round 3 -> IDLE next cycle, no done, ready=1; abort+start together in IDLE -> nothing accepted.
